// File: rtl/bids22_bidder.sv
// Proxy bidder for one bids22 auction port: keeps one step above the leading
// bid up to min(cap, balance) and reports the round outcome to the host.
module bids22_bidder #(
  parameter int TIMEOUT  = 8,
  parameter int MAX_BIDS = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] cap,
  input  logic [15:0] step,
  input  logic        retract_req,
  output logic        bid,
  output logic [15:0] bidAmt,
  output logic        retract,
  input  logic        ack,
  input  logic [1:0]  err,
  input  logic        win,
  input  logic        ready,
  input  logic        roundOver,
  input  logic [31:0] balance,
  input  logic [31:0] maxBid,
  output logic        leading,
  output logic        won,
  output logic        lost,
  output logic        capped,
  output logic        timeout,
  output logic [1:0]  last_err,
  output logic [7:0]  bid_count,
  output logic        busy
);

  localparam int           TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [7:0]   MAX_CNT  = 8'(MAX_BIDS);

  typedef enum logic [2:0] {
    IDLE, WATCH, BID, WAIT_RSP, LEAD, RETRACT, DONE
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [15:0]   bid_amt_n;
  logic          won_n, lost_n, capped_n, timeout_n;
  logic [1:0]    last_err_n;
  logic [7:0]    bid_count_n;

  logic [32:0]   target, limit;
  logic          over_limit, round_end;

  // Next bid is one step above the leader; a zero step still has to move the price.
  always_comb begin
    target     = {1'b0, maxBid} + {17'd0, ((step == 16'd0) ? 16'd1 : step)};
    limit      = ({17'd0, cap} < {1'b0, balance}) ? {17'd0, cap} : {1'b0, balance};
    over_limit = (target > limit);
    round_end  = roundOver && (state == WATCH || state == BID ||
                               state == WAIT_RSP || state == LEAD);
  end

  always_comb begin
    state_n     = state;
    tcnt_n      = tcnt;
    bid_amt_n   = bidAmt;
    won_n       = won;
    lost_n      = lost;
    capped_n    = capped;
    timeout_n   = timeout;
    last_err_n  = last_err;
    bid_count_n = bid_count;

    if (state == WATCH) capped_n = over_limit;
    if (state == BID && bid_count < MAX_CNT) bid_count_n = bid_count + 8'd1;

    // Disarm wins over everything except a retract already on the wire.
    if (!en && state != RETRACT) begin
      state_n = IDLE;
    end else if (round_end) begin
      state_n = DONE;
      won_n   = win;
      lost_n  = !win;
    end else begin
      case (state)
        IDLE: begin
          state_n     = WATCH;
          won_n       = 1'b0;
          lost_n      = 1'b0;
          timeout_n   = 1'b0;
          capped_n    = 1'b0;
          last_err_n  = 2'b00;
          bid_count_n = 8'd0;
        end
        WATCH: begin
          if (ready && !over_limit && bid_count < MAX_CNT) begin
            state_n   = BID;
            bid_amt_n = target[15:0];
          end
        end
        BID: begin
          state_n = WAIT_RSP;
          tcnt_n  = '0;
        end
        WAIT_RSP: begin
          if (err != 2'b00) begin
            last_err_n = err;
            if (err == 2'b01) begin
              state_n = DONE;
              lost_n  = 1'b1;
            end else begin
              state_n = WATCH;
            end
          end else if (ack) begin
            state_n = LEAD;
          end else if (tcnt == T_LAST) begin
            state_n   = WATCH;
            timeout_n = 1'b1;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        LEAD: begin
          if (maxBid > {16'd0, bidAmt}) state_n = WATCH;
          else if (retract_req)         state_n = RETRACT;
        end
        RETRACT: begin
          state_n = DONE;
          won_n   = 1'b0;
          lost_n  = 1'b0;
        end
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Strobes and status are decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      bid       <= 1'b0;
      bidAmt    <= 16'd0;
      retract   <= 1'b0;
      leading   <= 1'b0;
      won       <= 1'b0;
      lost      <= 1'b0;
      capped    <= 1'b0;
      timeout   <= 1'b0;
      last_err  <= 2'b00;
      bid_count <= 8'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      tcnt      <= tcnt_n;
      bid       <= (state_n == BID);
      bidAmt    <= bid_amt_n;
      retract   <= (state_n == RETRACT);
      leading   <= (state_n == LEAD);
      won       <= won_n;
      lost      <= lost_n;
      capped    <= capped_n;
      timeout   <= timeout_n;
      last_err  <= last_err_n;
      bid_count <= bid_count_n;
      busy      <= !(state_n == IDLE || state_n == DONE);
    end
  end

endmodule

// File: tb/tb_bids22_bidder.sv
// Directed bench for bids22_bidder: drives the auction side by hand, one cycle at a time.
module tb_bids22_bidder;

  logic        clk = 1'b0;
  logic        reset, en, retract_req, ack, win, ready, roundOver;
  logic [15:0] cap, step;
  logic [1:0]  err;
  logic [31:0] balance, maxBid;
  logic        bid, retract, leading, won, lost, capped, timeout, busy;
  logic [15:0] bidAmt;
  logic [1:0]  last_err;
  logic [7:0]  bid_count;

  int compared   = 0;
  int mismatched = 0;

  bids22_bidder #(.TIMEOUT(8), .MAX_BIDS(255)) dut (
    .clk(clk), .reset(reset), .en(en), .cap(cap), .step(step),
    .retract_req(retract_req), .bid(bid), .bidAmt(bidAmt), .retract(retract),
    .ack(ack), .err(err), .win(win), .ready(ready), .roundOver(roundOver),
    .balance(balance), .maxBid(maxBid), .leading(leading), .won(won),
    .lost(lost), .capped(capped), .timeout(timeout), .last_err(last_err),
    .bid_count(bid_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; outputs are then read 1ns after the last edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; retract_req = 1'b0; ack = 1'b0; win = 1'b0;
    ready = 1'b0; roundOver = 1'b0; cap = 16'd0; step = 16'd0; err = 2'b00;
    balance = 32'd0; maxBid = 32'd0;
    applyStimulus(2);
    reset = 1'b0;
    checkOutput("rst_bid", bid, 0);
    checkOutput("rst_amt", bidAmt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cnt", bid_count, 0);

    // Basic bid
    en = 1; cap = 100; step = 5; maxBid = 20; ready = 1; balance = 1000;
    applyStimulus(1);
    checkOutput("watch_busy", busy, 1);
    checkOutput("watch_nobid", bid, 0);
    applyStimulus(1);
    checkOutput("basic_bid", bid, 1);
    checkOutput("basic_amt", bidAmt, 25);
    applyStimulus(1);
    checkOutput("bid_pulse_end", bid, 0);
    checkOutput("cnt1", bid_count, 1);
    ack = 1;
    applyStimulus(1);
    ack = 0;
    checkOutput("lead1", leading, 1);

    // Outbid, rebid, then capped and lost round
    maxBid = 40;
    applyStimulus(1);
    checkOutput("outbid_drop", leading, 0);
    applyStimulus(1);
    checkOutput("rebid", bid, 1);
    checkOutput("rebid_amt", bidAmt, 45);
    applyStimulus(1);
    ack = 1;
    applyStimulus(1);
    ack = 0;
    checkOutput("lead2", leading, 1);
    maxBid = 96;
    applyStimulus(2);
    checkOutput("capped", capped, 1);
    checkOutput("capped_nobid", bid, 0);
    applyStimulus(1);
    checkOutput("capped_still_nobid", bid, 0);
    roundOver = 1; win = 0;
    applyStimulus(1);
    roundOver = 0;
    checkOutput("lost", lost, 1);
    checkOutput("lost_won", won, 0);
    checkOutput("done_busy", busy, 0);
    checkOutput("cnt2", bid_count, 2);

    // Errors
    en = 0;
    applyStimulus(1);
    checkOutput("sticky_lost", lost, 1);
    en = 1; maxBid = 20;
    applyStimulus(1);
    checkOutput("arm_clr_lost", lost, 0);
    checkOutput("arm_clr_capped", capped, 0);
    checkOutput("arm_clr_cnt", bid_count, 0);
    applyStimulus(2);
    err = 2'b10;
    applyStimulus(1);
    err = 2'b00;
    checkOutput("err10_last", last_err, 2);
    checkOutput("err10_nolead", leading, 0);
    applyStimulus(1);
    checkOutput("retry_bid", bid, 1);
    checkOutput("retry_amt", bidAmt, 25);
    applyStimulus(1);
    err = 2'b11; ack = 1;
    applyStimulus(1);
    err = 2'b00; ack = 0;
    checkOutput("err11_nolead", leading, 0);
    checkOutput("err11_last", last_err, 3);
    applyStimulus(1);
    checkOutput("retry2_bid", bid, 1);
    applyStimulus(1);
    err = 2'b01;
    applyStimulus(1);
    err = 2'b00;
    checkOutput("err01_last", last_err, 1);
    checkOutput("err01_lost", lost, 1);
    checkOutput("err01_busy", busy, 0);

    // Timeout
    en = 0;
    applyStimulus(1);
    en = 1;
    applyStimulus(3);
    checkOutput("to_cnt1", bid_count, 1);
    applyStimulus(7);
    checkOutput("to_not_yet", timeout, 0);
    applyStimulus(1);
    checkOutput("to_set", timeout, 1);
    applyStimulus(1);
    checkOutput("to_rebid", bid, 1);
    applyStimulus(1);
    checkOutput("to_cnt2", bid_count, 2);

    // Retract from LEAD
    ack = 1;
    applyStimulus(1);
    ack = 0;
    checkOutput("lead3", leading, 1);
    retract_req = 1;
    applyStimulus(1);
    retract_req = 0;
    checkOutput("retract", retract, 1);
    applyStimulus(1);
    checkOutput("retract_end", retract, 0);
    checkOutput("retract_won", won, 0);
    checkOutput("retract_busy", busy, 0);

    // Round end beats retract_req
    en = 0;
    applyStimulus(1);
    en = 1;
    applyStimulus(3);
    ack = 1;
    applyStimulus(1);
    ack = 0;
    retract_req = 1; roundOver = 1; win = 1;
    applyStimulus(1);
    retract_req = 0; roundOver = 0; win = 0;
    checkOutput("win_won", won, 1);
    checkOutput("win_noretract", retract, 0);
    checkOutput("win_lost", lost, 0);
    applyStimulus(1);
    checkOutput("win_noretract2", retract, 0);

    // Exact cap, zero step, reset mid-response
    en = 0;
    applyStimulus(1);
    en = 1; maxBid = 95; step = 5; cap = 100;
    applyStimulus(2);
    checkOutput("cap_exact_bid", bid, 1);
    checkOutput("cap_exact_amt", bidAmt, 100);
    checkOutput("cap_exact_capped", capped, 0);
    applyStimulus(1);
    err = 2'b10; maxBid = 30; step = 0;
    applyStimulus(1);
    err = 2'b00;
    applyStimulus(1);
    checkOutput("step0_bid", bid, 1);
    checkOutput("step0_amt", bidAmt, 31);
    applyStimulus(1);
    reset = 1;
    applyStimulus(1);
    checkOutput("rst2_amt", bidAmt, 0);
    checkOutput("rst2_busy", busy, 0);
    checkOutput("rst2_cnt", bid_count, 0);
    checkOutput("rst2_err", last_err, 0);
    reset = 0;

    // Balance below cap sets the limit
    balance = 50; cap = 100; maxBid = 45; step = 6;
    applyStimulus(2);
    checkOutput("bal_capped", capped, 1);
    checkOutput("bal_nobid", bid, 0);
    step = 5;
    applyStimulus(1);
    checkOutput("bal_exact_amt", bidAmt, 50);
    checkOutput("bal_exact_bid", bid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
